// File: rtl/fixed_self_attention_weight_scheduler.sv
// Weight-stream scheduler for the fixed self-attention block.
// Steers one shared weight tile stream into the query, key and value weight ports in
// head-major order: all Q tiles of head h, then K tiles, then V tiles, then head h+1.
// Steering is pure combinational pass-through (zero latency, no buffering).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, abort             begin a full load (IDLE only) / return to IDLE from any state
//   busy, done               routing in progress / one-cycle pulse after the final V tile
//   head_idx, proj_sel       current head / selected projection (0=Q 1=K 2=V 3=none)
//   weight_in*               shared tile stream (valid/ready)
//   query/key/value_weight*  per-projection tile streams (valid/ready)
module fixed_self_attention_weight_scheduler #(
  parameter int unsigned NUM_HEADS                = 12,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_0 = 768,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_1 = 768,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_0 = 4,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_1 = 4,
  parameter int unsigned WEIGHT_PRECISION_0       = 16,
  localparam int unsigned NumElems = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
  localparam int unsigned TILES_PER_HEAD =
      (WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0) *
      (WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_1) / NUM_HEADS,
  localparam int unsigned HeadW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  localparam int unsigned CntW  = (TILES_PER_HEAD > 1) ? $clog2(TILES_PER_HEAD) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [HeadW-1:0]              head_idx,
  output logic [1:0]                    proj_sel,
  input  logic [WEIGHT_PRECISION_0-1:0] weight_in [NumElems],
  input  logic                          weight_in_valid,
  output logic                          weight_in_ready,
  output logic [WEIGHT_PRECISION_0-1:0] query_weight [NumElems],
  output logic                          query_weight_valid,
  input  logic                          query_weight_ready,
  output logic [WEIGHT_PRECISION_0-1:0] key_weight [NumElems],
  output logic                          key_weight_valid,
  input  logic                          key_weight_ready,
  output logic [WEIGHT_PRECISION_0-1:0] value_weight [NumElems],
  output logic                          value_weight_valid,
  input  logic                          value_weight_ready
);

  // Tiles must split evenly across the matrix and across heads.
  if ((WEIGHT_TENSOR_SIZE_DIM_0 % WEIGHT_PARALLELISM_DIM_0) != 0 ||
      (WEIGHT_TENSOR_SIZE_DIM_1 % WEIGHT_PARALLELISM_DIM_1) != 0 ||
      (((WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0) *
        (WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_1)) % NUM_HEADS) != 0) begin : g_bad_cfg
    $error("weight tiling does not divide evenly across heads");
  end

  typedef enum logic [2:0] {StIdle, StRouteQ, StRouteK, StRouteV, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  tile_cnt_q, tile_cnt_d;
  logic [HeadW-1:0] head_q, head_d;
  logic             xfer, last_tile, last_head;

  // Data is always presented on every port; only the valids gate transfers.
  assign query_weight = weight_in;
  assign key_weight   = weight_in;
  assign value_weight = weight_in;

  assign head_idx  = head_q;
  assign xfer      = weight_in_valid & weight_in_ready;
  assign last_tile = (tile_cnt_q == CntW'(TILES_PER_HEAD - 1));
  assign last_head = (head_q == HeadW'(NUM_HEADS - 1));

  // Output decode and routing.
  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    proj_sel           = 2'd3;
    weight_in_ready    = 1'b0;
    query_weight_valid = 1'b0;
    key_weight_valid   = 1'b0;
    value_weight_valid = 1'b0;
    unique case (state_q)
      StRouteQ: begin
        busy               = 1'b1;
        proj_sel           = 2'd0;
        query_weight_valid = weight_in_valid;
        weight_in_ready    = query_weight_ready;
      end
      StRouteK: begin
        busy             = 1'b1;
        proj_sel         = 2'd1;
        key_weight_valid = weight_in_valid;
        weight_in_ready  = key_weight_ready;
      end
      StRouteV: begin
        busy               = 1'b1;
        proj_sel           = 2'd2;
        value_weight_valid = weight_in_valid;
        weight_in_ready    = value_weight_ready;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    head_d     = head_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StRouteQ;
          tile_cnt_d = '0;
          head_d     = '0;
        end
      end
      StRouteQ, StRouteK, StRouteV: begin
        if (xfer) begin
          if (last_tile) begin
            tile_cnt_d = '0;
            if (state_q == StRouteQ) begin
              state_d = StRouteK;
            end else if (state_q == StRouteK) begin
              state_d = StRouteV;
            end else if (last_head) begin
              state_d = StDone;
            end else begin
              state_d = StRouteQ;
              head_d  = head_q + 1'b1;
            end
          end else begin
            tile_cnt_d = tile_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        head_d  = '0;
      end
      default: state_d = StIdle;
    endcase
    // A transfer accepted during the abort cycle is deliberately not counted.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      tile_cnt_d = '0;
      head_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      tile_cnt_q <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      head_q     <= head_d;
    end
  end

endmodule

// File: tb/tb_fixed_self_attention_weight_scheduler.sv
module tb_fixed_self_attention_weight_scheduler;

  localparam int unsigned NH    = 2;
  localparam int unsigned PW    = 16;
  localparam int unsigned NE    = 4;
  localparam int          TPH   = 8;
  localparam int          TOTAL = 3 * 2 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort;
  logic          busy, done;
  logic [0:0]    head_idx;
  logic [1:0]    proj_sel;
  logic [PW-1:0] weight_in [NE];
  logic          weight_in_valid, weight_in_ready;
  logic [PW-1:0] query_weight [NE];
  logic [PW-1:0] key_weight [NE];
  logic [PW-1:0] value_weight [NE];
  logic          query_weight_valid, query_weight_ready;
  logic          key_weight_valid, key_weight_ready;
  logic          value_weight_valid, value_weight_ready;

  fixed_self_attention_weight_scheduler #(
    .NUM_HEADS               (NH),
    .WEIGHT_TENSOR_SIZE_DIM_0(8),
    .WEIGHT_TENSOR_SIZE_DIM_1(8),
    .WEIGHT_PARALLELISM_DIM_0(2),
    .WEIGHT_PARALLELISM_DIM_1(2),
    .WEIGHT_PRECISION_0      (PW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .head_idx          (head_idx),
    .proj_sel          (proj_sel),
    .weight_in         (weight_in),
    .weight_in_valid   (weight_in_valid),
    .weight_in_ready   (weight_in_ready),
    .query_weight      (query_weight),
    .query_weight_valid(query_weight_valid),
    .query_weight_ready(query_weight_ready),
    .key_weight        (key_weight),
    .key_weight_valid  (key_weight_valid),
    .key_weight_ready  (key_weight_ready),
    .value_weight      (value_weight),
    .value_weight_valid(value_weight_valid),
    .value_weight_ready(value_weight_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tag      = 0;   // next tile tag the upstream offers
  bit start_hold = 1'b0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int t);
    for (int i = 0; i < NE; i++) weight_in[i] = PW'(t * NE + i);
  endtask

  // One cycle inside a load: drive, then check routing against the tag model.
  task automatic drive(input bit v, input bit q_r, input bit k_r, input bit v_r);
    int ch, hd;
    bit sel_r, ok;
    @(negedge clk);
    start              = start_hold;
    weight_in_valid    = v;
    query_weight_ready = q_r;
    key_weight_ready   = k_r;
    value_weight_ready = v_r;
    set_data(tag);
    #1;
    ch    = (tag / TPH) % 3;
    hd    = tag / (3 * TPH);
    sel_r = (ch == 0) ? q_r : (ch == 1) ? k_r : v_r;
    check("busy", int'(busy), 1);
    check("proj_sel", int'(proj_sel), ch);
    check("head_idx", int'(head_idx), hd);
    check("q_valid", int'(query_weight_valid), int'(v && ch == 0));
    check("k_valid", int'(key_weight_valid), int'(v && ch == 1));
    check("v_valid", int'(value_weight_valid), int'(v && ch == 2));
    check("in_ready", int'(weight_in_ready), int'(sel_r));
    if (v && sel_r) begin
      ok = 1'b1;
      for (int i = 0; i < NE; i++) begin
        case (ch)
          0:       if (query_weight[i] != PW'(tag * NE + i)) ok = 1'b0;
          1:       if (key_weight[i]   != PW'(tag * NE + i)) ok = 1'b0;
          default: if (value_weight[i] != PW'(tag * NE + i)) ok = 1'b0;
        endcase
      end
      check("tile_data", int'(ok), 1);
      tag++;
    end
  endtask

  task automatic start_load(input bit hold);
    @(negedge clk);
    start           = 1'b1;
    weight_in_valid = 1'b0;
    #1;
    check("idle_busy", int'(busy), 0);
    check("idle_proj_sel", int'(proj_sel), 3);
    start_hold = hold;
    tag        = 0;
  endtask

  task automatic stream(input bit rnd, output int cycles);
    bit v, kr;
    cycles = 0;
    while (tag < TOTAL && cycles < 2000) begin
      v  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      kr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(v, 1'b1, kr, 1'b1);
      cycles++;
    end
    check("stream_complete", tag, TOTAL);
  endtask

  // DONE cycle then the IDLE cycle after it; upstream keeps offering with all readies high.
  task automatic finish_load(input bit s_done, input bit s_idle);
    @(negedge clk);
    start = s_done; weight_in_valid = 1'b1;
    query_weight_ready = 1'b1; key_weight_ready = 1'b1; value_weight_ready = 1'b1;
    #1;
    check("done_pulse", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_proj_sel", int'(proj_sel), 3);
    check("done_in_ready", int'(weight_in_ready), 0);
    check("done_valids", int'({value_weight_valid, key_weight_valid, query_weight_valid}), 0);
    @(negedge clk);
    start = s_idle;
    #1;
    check("after_done_done", int'(done), 0);
    check("after_done_busy", int'(busy), 0);
    check("after_done_proj_sel", int'(proj_sel), 3);
  endtask

  typedef struct {
    bit rst_n, st, ab, v, qr, kr, vr;
    bit e_busy, e_done, e_rdy;
    int e_proj;
    bit [2:0] e_vld;  // {value, key, query}
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc, d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; weight_in_valid = 1'b0;
    query_weight_ready = 1'b0; key_weight_ready = 1'b0; value_weight_ready = 1'b0;
    set_data(0);

    //            rst st ab v  qr kr vr  busy done rdy proj vld
    vecs[0]  = '{1, 0, 0, 1, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[1]  = '{1, 1, 1, 1, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[2]  = '{1, 0, 0, 1, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[3]  = '{1, 1, 0, 0, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[4]  = '{1, 0, 0, 1, 0, 1, 1,  1,   0,   0,  0,  3'b001};
    vecs[5]  = '{1, 0, 0, 0, 1, 1, 1,  1,   0,   1,  0,  3'b000};
    vecs[6]  = '{1, 0, 0, 1, 1, 0, 1,  1,   0,   1,  0,  3'b001};
    vecs[7]  = '{1, 0, 1, 1, 1, 1, 1,  1,   0,   1,  0,  3'b001};
    vecs[8]  = '{1, 0, 0, 0, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[9]  = '{0, 1, 0, 1, 1, 1, 1,  0,   0,   0,  3,  3'b000};
    vecs[10] = '{1, 0, 0, 1, 1, 1, 1,  0,   0,   0,  3,  3'b000};

    repeat (2) @(negedge clk);

    // Reset state, IDLE behaviour, abort-vs-start, routing during abort, reset-vs-start.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vecs[i].rst_n; start = vecs[i].st; abort = vecs[i].ab;
      weight_in_valid = vecs[i].v; query_weight_ready = vecs[i].qr;
      key_weight_ready = vecs[i].kr; value_weight_ready = vecs[i].vr;
      #1;
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      check($sformatf("vec%0d_proj_sel", i), int'(proj_sel), vecs[i].e_proj);
      check($sformatf("vec%0d_in_ready", i), int'(weight_in_ready), int'(vecs[i].e_rdy));
      check($sformatf("vec%0d_valids", i),
            int'({value_weight_valid, key_weight_valid, query_weight_valid}),
            int'(vecs[i].e_vld));
      check($sformatf("vec%0d_head_idx", i), int'(head_idx), 0);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b1;

    // Full load, always valid/ready; start raised during the DONE cycle must be ignored.
    d0 = done_cnt;
    start_load(1'b0);
    stream(1'b0, cyc);
    check("busy_cycles", cyc, TOTAL);
    finish_load(1'b1, 1'b0);
    check("done_count_full", done_cnt - d0, 1);

    // Random upstream valid and key backpressure.
    start_load(1'b0);
    stream(1'b1, cyc);
    finish_load(1'b0, 1'b0);

    // Q stalled for 10 cycles: nothing moves, K/V stay silent.
    start_load(1'b0);
    repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("stall_tag", tag, 0);
    stream(1'b0, cyc);
    finish_load(1'b0, 1'b0);

    // Abort while tile 13 is offered on K, head 0.
    d0 = done_cnt;
    start_load(1'b0);
    while (tag < 13) drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    abort = 1'b1; weight_in_valid = 1'b1; set_data(13);
    #1;
    check("abort_proj_sel", int'(proj_sel), 1);
    check("abort_k_valid", int'(key_weight_valid), 1);
    check("abort_in_ready", int'(weight_in_ready), 1);
    @(negedge clk);
    abort = 1'b0; weight_in_valid = 1'b0;
    #1;
    check("post_abort_busy", int'(busy), 0);
    check("post_abort_proj_sel", int'(proj_sel), 3);
    check("post_abort_done", int'(done), 0);
    @(negedge clk);
    #1;
    check("post_abort_done2", int'(done), 0);
    check("abort_no_done", done_cnt - d0, 0);
    start_load(1'b0);
    stream(1'b0, cyc);
    finish_load(1'b0, 1'b0);

    // One-cycle reset in the middle of ROUTE_V.
    start_load(1'b0);
    while (tag < 18) drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0; weight_in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valids", int'({value_weight_valid, key_weight_valid, query_weight_valid}), 0);
    check("rst_in_ready", int'(weight_in_ready), 0);
    check("rst_proj_sel", int'(proj_sel), 3);
    check("rst_head_idx", int'(head_idx), 0);
    check("rst_busy", int'(busy), 0);

    // start held high: back-to-back loads separated by DONE + IDLE only.
    d0 = done_cnt;
    start_load(1'b1);
    stream(1'b0, cyc);
    finish_load(1'b1, 1'b1);
    start_hold = 1'b0;
    tag = 0;
    stream(1'b0, cyc);
    check("b2b_cycles", cyc, TOTAL);
    finish_load(1'b0, 1'b0);
    check("b2b_done_count", done_cnt - d0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_self_attention_weight_scheduler.md
Name: fixed_self_attention_weight_scheduler

Overview:
Sequencer that feeds one shared weight stream (e.g. from a single off-chip or BRAM parameter loader) into the three weight ports of the fixed self-attention block (query, key, value). It steers tiles in head-major order: Q tiles of head h, then K tiles of head h, then V tiles of head h, then the next head. It provides start/busy/done control and a head index for upstream address generation. Data moves as zero-latency pass-through steering, with no buffering.

Parameters:
- NUM_HEADS, 12: number of attention heads.
- WEIGHT_TENSOR_SIZE_DIM_0, 768: weight matrix columns.
- WEIGHT_TENSOR_SIZE_DIM_1, 768: weight matrix rows.
- WEIGHT_PARALLELISM_DIM_0, 4: tile width.
- WEIGHT_PARALLELISM_DIM_1, 4: tile height.
- WEIGHT_PRECISION_0, 16: element bit width.
- TILES_PER_HEAD, derived as (DIM_0/PAR_0)*(DIM_1/PAR_1)/NUM_HEADS: tiles per projection per head. Default 3072. Exact divisibility is an elaboration-time requirement.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-low reset (rst=0 resets).
- start  in  1: begin one full weight load; sampled only in IDLE.
- abort  in  1: return to IDLE next cycle from any state.
- busy  out  1: high in ROUTE_Q/ROUTE_K/ROUTE_V.
- done  out  1: one-cycle pulse after the last V tile of the last head.
- head_idx  out  clog2(NUM_HEADS): current head.
- proj_sel  out  2: 0=Q, 1=K, 2=V, 3=idle/done.
- weight_in  in  WEIGHT_PRECISION_0 x (PAR_0*PAR_1) unpacked array: shared tile.
- weight_in_valid  in  1 / weight_in_ready  out  1: shared stream handshake.
- query_weight  out  same array: Q tile.
- query_weight_valid  out  1 / query_weight_ready  in  1: Q handshake.
- key_weight, key_weight_valid, key_weight_ready: K channel, same widths.
- value_weight, value_weight_valid, value_weight_ready: V channel, same widths.

Behaviour:
- FSM states: IDLE, ROUTE_Q, ROUTE_K, ROUTE_V, DONE.
- Reset (rst=0 at posedge):
  - State goes to IDLE; tile_cnt=0; head_idx=0.
  - busy=0, done=0, proj_sel=3.
  - All *_valid outputs=0; weight_in_ready=0.
- IDLE:
  - weight_in_ready=0 and all out valids=0.
  - start=1 moves to ROUTE_Q next cycle with tile_cnt=0 and head_idx=0.
- ROUTE_X, where X is the selected channel (combinational, zero latency):
  - X_valid = weight_in_valid.
  - weight_in_ready = X_ready.
  - X data = weight_in.
  - Non-selected valids = 0.
- Data on all three output arrays is driven from weight_in at all times; only the valids gate transfers.
- A transfer occurs when weight_in_valid & weight_in_ready; only a transfer advances tile_cnt.
- Transfer with tile_cnt == TILES_PER_HEAD-1:
  - tile_cnt wraps to 0.
  - Q goes to K, and K goes to V.
  - From V: if head_idx == NUM_HEADS-1, go to DONE; otherwise head_idx+1 and go to ROUTE_Q.
- DONE: done=1 for exactly one cycle, proj_sel=3, no ready asserted, then IDLE.
- start is ignored outside IDLE, including the DONE cycle.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and counters clear; no done pulse.
  - Combinational routing stays active during the abort cycle, so a transfer in that cycle is accepted and then discarded from the count.
- abort and start together in IDLE: abort wins and the FSM stays in IDLE.
- Reset mid-load gives the same result as abort; upstream must restart its stream.
- Backpressure: a stalled X_ready holds weight_in_ready low and state and counters frozen. No tile is duplicated or dropped.
- Total transfers per load = 3 * NUM_HEADS * TILES_PER_HEAD.
- Counter widths: clog2(TILES_PER_HEAD), with a minimum of 1 bit.

Test Plan:
Test parameters: NUM_HEADS=2, 8x8 matrix, 2x2 tiles, so TILES_PER_HEAD=8.
- Full load, always valid/ready, tiles tagged 0..47:
  - Tiles 0-7 appear on Q, 8-15 on K, 16-23 on V with head_idx=0; 24-47 repeat the pattern with head_idx=1.
  - done pulses one cycle after tile 47; busy is high for exactly 48 cycles.
- Random backpressure on key_weight_ready (50%) plus random weight_in_valid:
  - Each output channel receives the correct tags in order, none lost or duplicated.
  - weight_in_ready tracks the selected channel's ready exactly.
- Backpressure isolation: in ROUTE_Q hold query_weight_ready=0 for 10 cycles while key/value ready=1:
  - No transfer occurs; tile_cnt is unchanged.
  - key_weight_valid and value_weight_valid stay 0.
- Abort at tile 13 (ROUTE_K, head 0):
  - Next cycle is IDLE with busy=0 and no done pulse.
  - A following start restarts at Q, head 0, tile 0.
- Reset edge cases:
  - rst=0 for one cycle mid ROUTE_V gives all valids/ready=0, proj_sel=3, head_idx=0 on the next cycle.
  - start asserted during DONE is ignored.
- start held high continuously:
  - Back-to-back loads run, separated by exactly the DONE and IDLE cycles (2 idle cycles).
  - done pulses once per load.
